comb_msetting_ctrl: RTL and testbench
=====================================

# comb_msetting_ctrl

Run-time controller for the programmable differential delay (M) of a single comb stage. It accepts new M requests over a valid/ready config port and range-checks them. Each accepted change is sequenced as drain → reset → apply → refill, so the comb never emits samples computed across two different delay settings. The block sits between the channelizer's register/config path and one comb instance, gating that comb's input and output valid strobes.

## Interface
Parameters:
- MSET_WIDTH, 9: width of the M setting.
- MIN_M, 1: smallest legal M.
- MAX_M, 256: largest legal M.
- DEFAULT_M, 256: M applied after reset.
- COMB_LATENCY, 10: input-to-output latency of the controlled comb, in clocks.
- RESET_CYCLES, 2: cycles the comb's sync reset is held.

Ports:
- clk  in  1  sole clock.
- async_reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- cfg_tvalid  in  1  new M request valid.
- cfg_tdata  in  MSET_WIDTH  requested M.
- cfg_tready  out  1  request accepted when high with cfg_tvalid.
- cfg_err  out  1  one-cycle pulse: request rejected, out of range.
- s_axis_tvalid  in  1  upstream sample strobe.
- comb_in_tvalid  out  1  gated strobe to the comb input.
- comb_out_tvalid  in  1  comb output valid.
- m_axis_tvalid  out  1  gated comb output valid.
- msetting  out  MSET_WIDTH  delay setting driven to the comb.
- comb_sync_reset  out  1  active-high sync reset to the comb.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  16  saturating count of input samples dropped during a reconfiguration.

## Operation
- States: IDLE, DRAIN, RST, FILL.
- IDLE:
  - cfg_tready=1, comb_in_tvalid=s_axis_tvalid, m_axis_tvalid=comb_out_tvalid.
  - On handshake with cfg_tdata outside [MIN_M, MAX_M]: pulse cfg_err, stay in IDLE.
  - On handshake with cfg_tdata equal to msetting: ack only, stay in IDLE, no disturbance.
  - Otherwise: latch pending=cfg_tdata → DRAIN.
- DRAIN:
  - comb_in_tvalid=0; each s_axis_tvalid increments drop_cnt.
  - m_axis_tvalid=comb_out_tvalid, because in-flight samples were computed with the old M and are valid.
  - After COMB_LATENCY cycles → RST.
- RST:
  - comb_sync_reset=1, comb_in_tvalid=0, m_axis_tvalid=0; drops are counted.
  - msetting<=pending on entry.
  - After RESET_CYCLES cycles → FILL.
- FILL:
  - comb_in_tvalid=s_axis_tvalid; m_axis_tvalid=0.
  - fill_cnt counts forwarded samples.
  - When fill_cnt reaches msetting, that sample's output and all later outputs are released → IDLE.
- cfg_tready=0 outside IDLE; a request presented then is held off, never lost or queued.
- drop_cnt saturates at 0xFFFF and clears only on reset.
- fill_cnt is MSET_WIDTH+1 bits, so MAX_M=2^(MSET_WIDTH-1) is counted without wrap.

## Timing
- All outputs are registered except the gated valids: comb_in_tvalid and m_axis_tvalid are AND of input with a registered enable, zero latency.
- Reset values (async assert):
  - state=RST with count 0, msetting=DEFAULT_M, comb_sync_reset=1.
  - cfg_tready=0, cfg_err=0, busy=1, drop_cnt=0.
  - comb_in_tvalid=0, m_axis_tvalid=0.
- After reset deassertion: RST completes (RESET_CYCLES) → FILL → IDLE. Reset mid-sequence discards pending and reapplies DEFAULT_M.
- Config accepted at cycle 0 produces:
  - DRAIN cycles 1..COMB_LATENCY.
  - RST cycles COMB_LATENCY+1..COMB_LATENCY+RESET_CYCLES.
  - msetting changes at the start of cycle COMB_LATENCY+1.
  - FILL from COMB_LATENCY+RESET_CYCLES+1.
- s_axis_tvalid in the same cycle as the config handshake is forwarded, since the state is still IDLE.
- cfg_err asserts the cycle after the rejected handshake, for exactly one cycle.

## Structure
- Package comb_ctrl_pkg: state enum (IDLE, DRAIN, RST, FILL), DROP_CNT_WIDTH=16, and the shared MSET_WIDTH default.
- Single module; one phase counter is reused by DRAIN and RST, plus a separate fill_cnt. No sub-module required.

## Test plan
- Reset release, DEFAULT_M=256, continuous s_axis_tvalid:
  - comb_sync_reset high through cycle 2 after release.
  - m_axis_tvalid=0 for the first 255 forwarded samples; first pass-through on the 256th; busy falls with it.
- Request M=64 in IDLE at cycle 0 with continuous input:
  - comb_in_tvalid low cycles 1..12; msetting=64 from cycle 11; comb_sync_reset cycles 11..12.
  - drop_cnt=12; outputs released after 64 forwarded samples.
- Request M=0 and M=300:
  - cfg_err pulses once for each; msetting unchanged; busy stays 0.
- Request M equal to the current msetting:
  - ack in one cycle; no DRAIN entry; drop_cnt unchanged.
- cfg_tvalid held high with M=32 while busy from a prior M=64 change:
  - cfg_tready=0 until IDLE; then accepted and a second full sequence runs.
- async_reset_n asserted during FILL:
  - all outputs take reset values immediately; msetting=DEFAULT_M; drop_cnt=0; the sequence restarts from RST.

Source files
------------

// File: rtl/comb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : comb_ctrl_pkg
// Brief  : Shared types and widths for the comb M-setting controller.
// Rev    : 1.0
// ============================================================================
package comb_ctrl_pkg;

    localparam int DEF_MSET_WIDTH = 9;
    localparam int DROP_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RST   = 2'd2,
        FILL  = 2'd3
    } comb_state_e;

endpackage : comb_ctrl_pkg
`default_nettype wire

// File: rtl/comb_msetting_ctrl.sv
`default_nettype none
// ============================================================================
// Module : comb_msetting_ctrl
// Brief  : Sequences run-time M changes of one comb (drain, reset, apply,
//          refill) and gates the comb's input/output valid strobes.
// Rev    : 1.0
// ============================================================================
module comb_msetting_ctrl
    import comb_ctrl_pkg::*;
#(
    parameter int MSET_WIDTH   = DEF_MSET_WIDTH,
    parameter int MIN_M        = 1,
    parameter int MAX_M        = 256,
    parameter int DEFAULT_M    = 256,
    parameter int COMB_LATENCY = 10,
    parameter int RESET_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      async_reset_n,
    input  logic                      cfg_tvalid,
    input  logic [MSET_WIDTH-1:0]     cfg_tdata,
    output logic                      cfg_tready,
    output logic                      cfg_err,
    input  logic                      s_axis_tvalid,
    output logic                      comb_in_tvalid,
    input  logic                      comb_out_tvalid,
    output logic                      m_axis_tvalid,
    output logic [MSET_WIDTH-1:0]     msetting,
    output logic                      comb_sync_reset,
    output logic                      busy,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam int PHASE_MAX = (COMB_LATENCY > RESET_CYCLES) ? COMB_LATENCY : RESET_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [PHASE_W-1:0]    DRAIN_LAST  = PHASE_W'(COMB_LATENCY - 1);
    localparam logic [PHASE_W-1:0]    RST_LAST    = PHASE_W'(RESET_CYCLES - 1);
    localparam logic [MSET_WIDTH:0]   MIN_M_X     = (MSET_WIDTH + 1)'(MIN_M);
    localparam logic [MSET_WIDTH:0]   MAX_M_X     = (MSET_WIDTH + 1)'(MAX_M);
    localparam logic [MSET_WIDTH-1:0] DEFAULT_M_W = MSET_WIDTH'(DEFAULT_M);

    comb_state_e                state_q, state_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [MSET_WIDTH:0]        fill_cnt_q, fill_cnt_d;
    logic [MSET_WIDTH-1:0]      msetting_q, msetting_d;
    logic [MSET_WIDTH-1:0]      pending_q, pending_d;
    logic [DROP_CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                       cfg_err_q, cfg_err_d;
    logic                       cfg_tready_q, cfg_tready_d;
    logic                       busy_q, busy_d;
    logic                       sync_rst_q, sync_rst_d;
    logic                       in_en_q, in_en_d;
    logic                       out_en_q, out_en_d;

    logic                       cfg_hs;
    logic [MSET_WIDTH:0]        cfg_ext;
    logic [MSET_WIDTH:0]        fill_next;

    assign cfg_hs    = cfg_tvalid & cfg_tready_q;
    assign cfg_ext   = {1'b0, cfg_tdata};
    assign fill_next = fill_cnt_q + (MSET_WIDTH + 1)'(1);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        fill_cnt_d = fill_cnt_q;
        msetting_d = msetting_q;
        pending_d  = pending_q;
        drop_cnt_d = drop_cnt_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    if ((cfg_ext < MIN_M_X) || (cfg_ext > MAX_M_X)) begin
                        cfg_err_d = 1'b1;
                    end else if (cfg_tdata != msetting_q) begin
                        pending_d = cfg_tdata;
                        phase_d   = '0;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (phase_q == DRAIN_LAST) begin
                    phase_d    = '0;
                    msetting_d = pending_q;
                    state_d    = RST;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            RST: begin
                if (phase_q == RST_LAST) begin
                    phase_d    = '0;
                    fill_cnt_d = '0;
                    state_d    = FILL;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            FILL: begin
                // Release once the delay line holds msetting samples of the new M.
                if (s_axis_tvalid) begin
                    fill_cnt_d = fill_next;
                    if (fill_next == {1'b0, msetting_q}) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = RST;
        endcase

        if (((state_q == DRAIN) || (state_q == RST)) && s_axis_tvalid &&
            (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end

        // Status and gate enables are decoded from the next state so they are flops.
        cfg_tready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        sync_rst_d   = (state_d == RST);
        in_en_d      = (state_d == IDLE) || (state_d == FILL);
        out_en_d     = (state_d == IDLE) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q      <= RST;
            phase_q      <= '0;
            fill_cnt_q   <= '0;
            msetting_q   <= DEFAULT_M_W;
            pending_q    <= DEFAULT_M_W;
            drop_cnt_q   <= '0;
            cfg_err_q    <= 1'b0;
            cfg_tready_q <= 1'b0;
            busy_q       <= 1'b1;
            sync_rst_q   <= 1'b1;
            in_en_q      <= 1'b0;
            out_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            fill_cnt_q   <= fill_cnt_d;
            msetting_q   <= msetting_d;
            pending_q    <= pending_d;
            drop_cnt_q   <= drop_cnt_d;
            cfg_err_q    <= cfg_err_d;
            cfg_tready_q <= cfg_tready_d;
            busy_q       <= busy_d;
            sync_rst_q   <= sync_rst_d;
            in_en_q      <= in_en_d;
            out_en_q     <= out_en_d;
        end
    end

    assign cfg_tready      = cfg_tready_q;
    assign cfg_err         = cfg_err_q;
    assign busy            = busy_q;
    assign comb_sync_reset = sync_rst_q;
    assign msetting        = msetting_q;
    assign drop_cnt        = drop_cnt_q;
    assign comb_in_tvalid  = s_axis_tvalid & in_en_q;
    assign m_axis_tvalid   = comb_out_tvalid & out_en_q;

endmodule : comb_msetting_ctrl
`default_nettype wire

// File: tb/tb_comb_msetting_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_comb_msetting_ctrl
// Brief  : Directed scoreboard bench for comb_msetting_ctrl with a delay-line
//          model of the controlled comb's valid path.
// Rev    : 1.0
// ============================================================================
module tb_comb_msetting_ctrl;

    localparam int MW    = 9;
    localparam int LAT   = 10;
    localparam int RC    = 2;
    localparam int DEF_M = 256;

    logic          clk = 1'b0;
    logic          async_reset_n;
    logic          cfg_tvalid;
    logic [MW-1:0] cfg_tdata;
    logic          cfg_tready;
    logic          cfg_err;
    logic          s_axis_tvalid;
    logic          comb_in_tvalid;
    logic          comb_out_tvalid;
    logic          m_axis_tvalid;
    logic [MW-1:0] msetting;
    logic          comb_sync_reset;
    logic          busy;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    comb_msetting_ctrl #(
        .MSET_WIDTH   (MW),
        .MIN_M        (1),
        .MAX_M        (256),
        .DEFAULT_M    (DEF_M),
        .COMB_LATENCY (LAT),
        .RESET_CYCLES (RC)
    ) dut (
        .clk             (clk),
        .async_reset_n   (async_reset_n),
        .cfg_tvalid      (cfg_tvalid),
        .cfg_tdata       (cfg_tdata),
        .cfg_tready      (cfg_tready),
        .cfg_err         (cfg_err),
        .s_axis_tvalid   (s_axis_tvalid),
        .comb_in_tvalid  (comb_in_tvalid),
        .comb_out_tvalid (comb_out_tvalid),
        .m_axis_tvalid   (m_axis_tvalid),
        .msetting        (msetting),
        .comb_sync_reset (comb_sync_reset),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    // Comb valid path: output valid is the input valid LAT clocks earlier.
    logic [LAT-1:0] comb_pipe;
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) comb_pipe <= '0;
        else                comb_pipe <= {comb_pipe[LAT-2:0], comb_in_tvalid};
    end
    assign comb_out_tvalid = comb_pipe[LAT-1];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic ci [1:13];
    logic sr [1:13];
    logic mx [1:13];
    logic [MW-1:0] ms [1:13];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed %0d expected a queued entry", obs);
            return;
        end
        e = sb_q.pop_front();
        chk(e.tag, obs, e.val);
    endtask

    task automatic wait_idle(output int n, output int leaks, output int rdy_hi);
        n = 0;
        leaks = 0;
        rdy_hi = 0;
        for (int i = 0; i < 1000; i++) begin
            next_cycle();
            settle();
            if (!busy) return;
            n++;
            if (comb_in_tvalid && m_axis_tvalid) leaks++;
            if (cfg_tready) rdy_hi++;
        end
        checks++;
        errors++;
        $error("FAIL wait_idle: observed busy=1 after 1000 cycles expected busy=0");
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_tready"}, cfg_tready, 0);
        chk({pfx, "_err"}, cfg_err, 0);
        chk({pfx, "_busy"}, busy, 1);
        chk({pfx, "_drop"}, drop_cnt, 0);
        chk({pfx, "_in_v"}, comb_in_tvalid, 0);
        chk({pfx, "_out_v"}, m_axis_tvalid, 0);
        chk({pfx, "_mset"}, msetting, DEF_M);
        chk({pfx, "_srst"}, comb_sync_reset, 1);
    endtask

    // Release reset with continuous input and follow RST -> FILL -> IDLE.
    task automatic release_and_fill(input string pfx);
        logic s1, s2, s3;
        int   n, lk, rh;
        next_cycle();
        async_reset_n = 1'b1;
        settle();
        s1 = comb_sync_reset;
        next_cycle(); settle();
        s2 = comb_sync_reset;
        next_cycle(); settle();
        s3 = comb_sync_reset;
        chk({pfx, "_srst_c1"}, s1, 1);
        chk({pfx, "_srst_c2"}, s2, 1);
        chk({pfx, "_srst_c3"}, s3, 0);
        chk({pfx, "_drop_rst"}, drop_cnt, RC);
        chk({pfx, "_fill_fwd"}, comb_in_tvalid, 1);
        sb_push({pfx, "_fill_cycles"}, DEF_M);
        sb_push({pfx, "_fill_leaks"}, 0);
        wait_idle(n, lk, rh);
        sb_check(n + 1);
        sb_check(lk);
        chk({pfx, "_idle_mset"}, msetting, DEF_M);
        chk({pfx, "_idle_pass"}, m_axis_tvalid, 1);
        chk({pfx, "_idle_tready"}, cfg_tready, 1);
    endtask

    initial begin
        int base_drop;
        int lowcnt;
        int rdycnt;
        int n, lk, rh;
        int bad [3];

        bad = '{0, 300, 257};
        async_reset_n = 1'b1;
        cfg_tvalid    = 1'b0;
        cfg_tdata     = '0;
        s_axis_tvalid = 1'b1;
        #1 async_reset_n = 1'b0;
        #1;
        chk_reset_vals("por");

        release_and_fill("por");

        // Change to M=64, then hold a request for M=32 while busy.
        base_drop = int'(drop_cnt);
        cfg_tvalid = 1'b1;
        cfg_tdata  = MW'(64);
        settle();
        chk("m64_hs_fwd", comb_in_tvalid, 1);
        sb_push("m64_drop", 12);
        sb_push("m64_mset", 64);
        sb_push("m64_busy_cycles", 76);
        sb_push("m64_fill_leaks", 0);
        sb_push("m32_held_tready", 0);
        rdycnt = 0;
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            if (c == 1) cfg_tdata = MW'(32);
            settle();
            ci[c] = comb_in_tvalid;
            sr[c] = comb_sync_reset;
            mx[c] = m_axis_tvalid;
            ms[c] = msetting;
            if (cfg_tready) rdycnt++;
        end
        lowcnt = 0;
        for (int c = 1; c <= 12; c++) if (!ci[c]) lowcnt++;
        chk("m64_in_gated", lowcnt, 12);
        chk("m64_in_fill", ci[13], 1);
        chk("m64_mset_c10", ms[10], DEF_M);
        chk("m64_mset_c11", ms[11], 64);
        chk("m64_srst_c10", sr[10], 0);
        chk("m64_srst_c11", sr[11], 1);
        chk("m64_srst_c12", sr[12], 1);
        chk("m64_srst_c13", sr[13], 0);
        chk("m64_drain_pass", mx[5], 1);
        sb_check(int'(drop_cnt) - base_drop);
        sb_check(msetting);
        wait_idle(n, lk, rh);
        sb_check(13 + n);
        sb_check(lk);
        sb_check(rdycnt + rh);

        chk("m32_accept", cfg_tready, 1);
        base_drop = int'(drop_cnt);
        sb_push("m32_busy_cycles", 44);
        sb_push("m32_drop", 12);
        sb_push("m32_mset", 32);
        next_cycle();
        cfg_tvalid = 1'b0;
        settle();
        chk("m32_drain", busy, 1);
        wait_idle(n, lk, rh);
        sb_check(1 + n);
        sb_check(int'(drop_cnt) - base_drop);
        sb_check(msetting);

        // Out-of-range requests, including both sides of the legal window.
        for (int i = 0; i < 3; i++) begin
            cfg_tvalid = 1'b1;
            cfg_tdata  = MW'(bad[i]);
            settle();
            chk($sformatf("bad%0d_err_early", bad[i]), cfg_err, 0);
            sb_push($sformatf("bad%0d_err_pulse", bad[i]), 1);
            next_cycle();
            cfg_tvalid = 1'b0;
            settle();
            sb_check(cfg_err);
            chk($sformatf("bad%0d_busy", bad[i]), busy, 0);
            next_cycle();
            settle();
            chk($sformatf("bad%0d_err_single", bad[i]), cfg_err, 0);
            chk($sformatf("bad%0d_mset", bad[i]), msetting, 32);
        end

        // Request equal to the current setting.
        base_drop  = int'(drop_cnt);
        cfg_tvalid = 1'b1;
        cfg_tdata  = MW'(32);
        settle();
        chk("same_tready", cfg_tready, 1);
        next_cycle();
        cfg_tvalid = 1'b0;
        settle();
        chk("same_busy", busy, 0);
        chk("same_err", cfg_err, 0);
        chk("same_drop", drop_cnt, base_drop);
        s_axis_tvalid = 1'b0;
        settle();
        chk("idle_no_in", comb_in_tvalid, 0);
        s_axis_tvalid = 1'b1;

        // Reset asserted during FILL of an M=16 change.
        cfg_tvalid = 1'b1;
        cfg_tdata  = MW'(16);
        next_cycle();
        cfg_tvalid = 1'b0;
        repeat (15) next_cycle();
        settle();
        chk("m16_fill_busy", busy, 1);
        chk("m16_fill_fwd", comb_in_tvalid, 1);
        chk("m16_fill_mset", msetting, 16);
        #1 async_reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        next_cycle();
        next_cycle();
        release_and_fill("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_comb_msetting_ctrl
`default_nettype wire
